// File: rtl/id_stage.sv
// Instruction-decode stage of a 5-stage MIPS-like pipeline: holds the IF/ID
// register, decodes control, reads the register file (with writeback
// bypass), detects load-use hazards and resolves beq/j for fetch redirect.
module id_stage (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] Instruction_if,
  input  logic [31:0] NextPC_if,
  input  logic        IF_flush,
  input  logic        RegWrite_wb,
  input  logic [4:0]  WriteReg_wb,
  input  logic [31:0] WriteData_wb,
  input  logic        MemRead_ex,
  input  logic [4:0]  RegisterRt_ex,
  output logic        IFWrite,
  output logic        Branch,
  output logic        Jump,
  output logic [31:0] JumpAddr,
  output logic [31:0] ReadData1_id,
  output logic [31:0] ReadData2_id,
  output logic [31:0] Imm_id,
  output logic [4:0]  Rs_id,
  output logic [4:0]  Rt_id,
  output logic [4:0]  Rd_id,
  output logic [31:0] NextPC_id,
  output logic [7:0]  Ctrl_id
);

  localparam logic [5:0] OpRType = 6'h00;
  localparam logic [5:0] OpLw    = 6'h23;
  localparam logic [5:0] OpSw    = 6'h2B;
  localparam logic [5:0] OpBeq   = 6'h04;
  localparam logic [5:0] OpAddi  = 6'h08;
  localparam logic [5:0] OpJ     = 6'h02;

  logic [31:0] instr_q;
  logic [31:0] pc_q;
  logic [31:0] rf_q [32];

  logic [5:0]  opcode;
  logic        stall;
  logic        uses_rt;
  logic [7:0]  ctrl_raw;
  logic        is_beq;
  logic        is_j;

  assign opcode    = instr_q[31:26];
  assign Rs_id     = instr_q[25:21];
  assign Rt_id     = instr_q[20:16];
  assign Rd_id     = instr_q[15:11];
  assign Imm_id    = {{16{instr_q[15]}}, instr_q[15:0]};
  assign NextPC_id = pc_q;

  // IF/ID register: stall holds, flush inserts a nop, otherwise capture fetch.
  always_ff @(posedge clk) begin
    if (reset) begin
      instr_q <= '0;
      pc_q    <= '0;
    end else if (IFWrite) begin
      if (IF_flush) begin
        instr_q <= '0;
        pc_q    <= '0;
      end else begin
        instr_q <= Instruction_if;
        pc_q    <= NextPC_if;
      end
    end
  end

  // Register file write port; $0 is never written so it always reads zero.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < 32; i++) rf_q[i] <= '0;
    end else if (RegWrite_wb && (WriteReg_wb != 5'd0)) begin
      rf_q[WriteReg_wb] <= WriteData_wb;
    end
  end

  // Combinational reads with write-through so WB and ID can share a cycle.
  always_comb begin
    ReadData1_id = rf_q[Rs_id];
    ReadData2_id = rf_q[Rt_id];
    if (Rs_id == 5'd0) begin
      ReadData1_id = '0;
    end else if (RegWrite_wb && (WriteReg_wb == Rs_id)) begin
      ReadData1_id = WriteData_wb;
    end
    if (Rt_id == 5'd0) begin
      ReadData2_id = '0;
    end else if (RegWrite_wb && (WriteReg_wb == Rt_id)) begin
      ReadData2_id = WriteData_wb;
    end
  end

  // Main decoder; an all-zero word is a nop, not an R-type.
  always_comb begin
    ctrl_raw = 8'h00;
    unique case (opcode)
      OpRType: ctrl_raw = (instr_q != 32'd0) ? 8'b1000_0110 : 8'h00;
      OpLw:    ctrl_raw = 8'b0110_1100;
      OpSw:    ctrl_raw = 8'b0101_0000;
      OpBeq:   ctrl_raw = 8'b0000_0001;
      OpAddi:  ctrl_raw = 8'b0100_0100;
      default: ctrl_raw = 8'h00;
    endcase
  end

  // Load-use hazard: rt only matters for formats that actually read it.
  always_comb begin
    uses_rt = (opcode == OpRType) || (opcode == OpSw) || (opcode == OpBeq);
    stall   = MemRead_ex && (RegisterRt_ex != 5'd0) &&
              ((RegisterRt_ex == Rs_id) || ((RegisterRt_ex == Rt_id) && uses_rt));
  end

  assign is_beq = (opcode == OpBeq);
  assign is_j   = (opcode == OpJ);

  // Hazard bubble, early branch/jump resolution and redirect target.
  always_comb begin
    IFWrite  = ~stall;
    Ctrl_id  = stall ? 8'h00 : ctrl_raw;
    Branch   = is_beq && (ReadData1_id == ReadData2_id) && ~stall;
    Jump     = is_j && ~stall;
    JumpAddr = Jump ? {pc_q[31:28], instr_q[25:0], 2'b00}
                    : pc_q + {Imm_id[29:0], 2'b00};
  end

endmodule

// File: tb/tb_id_stage.sv
// Scoreboard bench for id_stage: the stimulus process drives one cycle of
// inputs and queues the outputs expected for that cycle; a monitor pops and
// compares them on the falling edge.
module tb_id_stage;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] Instruction_if, NextPC_if;
  logic        IF_flush, RegWrite_wb, MemRead_ex;
  logic [4:0]  WriteReg_wb, RegisterRt_ex;
  logic [31:0] WriteData_wb;
  logic        IFWrite, Branch, Jump;
  logic [31:0] JumpAddr, ReadData1_id, ReadData2_id, Imm_id, NextPC_id;
  logic [4:0]  Rs_id, Rt_id, Rd_id;
  logic [7:0]  Ctrl_id;

  always #5 clk = ~clk;

  id_stage dut (
    .clk(clk), .reset(reset), .Instruction_if(Instruction_if), .NextPC_if(NextPC_if),
    .IF_flush(IF_flush), .RegWrite_wb(RegWrite_wb), .WriteReg_wb(WriteReg_wb),
    .WriteData_wb(WriteData_wb), .MemRead_ex(MemRead_ex), .RegisterRt_ex(RegisterRt_ex),
    .IFWrite(IFWrite), .Branch(Branch), .Jump(Jump), .JumpAddr(JumpAddr),
    .ReadData1_id(ReadData1_id), .ReadData2_id(ReadData2_id), .Imm_id(Imm_id),
    .Rs_id(Rs_id), .Rt_id(Rt_id), .Rd_id(Rd_id), .NextPC_id(NextPC_id), .Ctrl_id(Ctrl_id)
  );

  typedef enum int {SIfw, SBr, SJmp, SJa, SRd1, SRd2, SImm, SRs, SPc, SCtrl} sel_e;
  typedef struct {
    string       name;
    sel_e        sel;
    logic [31:0] exp;
  } exp_t;

  exp_t sb_q[$];
  int   checks = 0;
  int   failures = 0;

  function automatic logic [31:0] actual(sel_e s);
    case (s)
      SIfw:  return {31'd0, IFWrite};
      SBr:   return {31'd0, Branch};
      SJmp:  return {31'd0, Jump};
      SJa:   return JumpAddr;
      SRd1:  return ReadData1_id;
      SRd2:  return ReadData2_id;
      SImm:  return Imm_id;
      SRs:   return {27'd0, Rs_id};
      SPc:   return NextPC_id;
      default: return {24'd0, Ctrl_id};
    endcase
  endfunction

  // Monitor: outputs are stable mid-cycle, compare everything queued.
  always @(negedge clk) begin
    while (sb_q.size() > 0) begin
      exp_t e;
      logic [31:0] a;
      e = sb_q.pop_front();
      a = actual(e.sel);
      checks++;
      if (a !== e.exp) begin
        failures++;
        $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", e.name, a, e.exp, $time);
      end
    end
  end

  task automatic expect_v(input string name, input sel_e s, input logic [31:0] v);
    exp_t e;
    e.name = name; e.sel = s; e.exp = v;
    sb_q.push_back(e);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [31:0] ins, input logic [31:0] pc, input logic fl,
                       input logic rw, input logic [4:0] wr, input logic [31:0] wd,
                       input logic mr, input logic [4:0] rt);
    Instruction_if = ins; NextPC_if = pc; IF_flush = fl;
    RegWrite_wb = rw; WriteReg_wb = wr; WriteData_wb = wd;
    MemRead_ex = mr; RegisterRt_ex = rt;
  endtask

  initial begin
    reset = 1'b1;
    drive(32'h0, 32'h0, 1'b0, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0);
    tick();
    reset = 1'b0;

    // Post-reset state; write $1 this cycle.
    drive(32'h0, 32'h0, 1'b0, 1'b1, 5'd1, 32'h11, 1'b0, 5'd0);
    expect_v("rst_ifwrite", SIfw, 32'd1);
    expect_v("rst_branch", SBr, 32'd0);
    expect_v("rst_jump", SJmp, 32'd0);
    expect_v("rst_ctrl", SCtrl, 32'h0);
    expect_v("rst_nextpc", SPc, 32'h0);
    expect_v("rst_jumpaddr", SJa, 32'h0);
    tick();
    drive(32'h0, 32'h0, 1'b0, 1'b1, 5'd2, 32'h11, 1'b0, 5'd0);
    tick();
    drive(32'h0, 32'h0, 1'b0, 1'b1, 5'd3, 32'h22, 1'b0, 5'd0);
    tick();

    // WB $5=0x1234 while fetching add $6,$5,$0.
    drive(32'h00A03020, 32'h4, 1'b0, 1'b1, 5'd5, 32'h1234, 1'b0, 5'd0);
    tick();
    drive(32'h00E05020, 32'h8, 1'b0, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0);
    expect_v("add_rd1", SRd1, 32'h1234);
    expect_v("add_rd2", SRd2, 32'h0);
    expect_v("add_ctrl", SCtrl, 32'h86);
    expect_v("add_nextpc", SPc, 32'h4);
    expect_v("add_rs", SRs, 32'd5);
    tick();
    // ID reads $7 while WB writes it: bypass.
    drive(32'h00075820, 32'hC, 1'b0, 1'b1, 5'd7, 32'hABCD, 1'b0, 5'd0);
    expect_v("bypass_rd1", SRd1, 32'hABCD);
    tick();
    // WB to $0 while ID reads $0 and $7.
    drive(32'hFC000000, 32'h10, 1'b0, 1'b1, 5'd0, 32'hFFFF_FFFF, 1'b0, 5'd0);
    expect_v("r0_bypass_rd1", SRd1, 32'h0);
    expect_v("r7_stored_rd2", SRd2, 32'hABCD);
    tick();
    // Unknown opcode decodes to zero control.
    drive(32'h01014820, 32'h100, 1'b0, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0);
    expect_v("badop_ctrl", SCtrl, 32'h0);
    tick();

    // Load-use stall on rs: add $9,$8,$1 with lw $8 in EX.
    drive(32'h20040005, 32'h104, 1'b0, 1'b0, 5'd0, 32'h0, 1'b1, 5'd8);
    expect_v("stall_ifwrite", SIfw, 32'd0);
    expect_v("stall_ctrl", SCtrl, 32'h0);
    expect_v("stall_branch", SBr, 32'd0);
    tick();
    drive(32'h20040005, 32'h104, 1'b0, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0);
    expect_v("held_ifwrite", SIfw, 32'd1);
    expect_v("held_ctrl", SCtrl, 32'h86);
    expect_v("held_nextpc", SPc, 32'h100);
    expect_v("held_rs", SRs, 32'd8);
    tick();
    // addi $4,$0,5 with load to $4 in EX: rt is a destination, no stall.
    drive(32'h1022FFFF, 32'h40, 1'b0, 1'b0, 5'd0, 32'h0, 1'b1, 5'd4);
    expect_v("addi_ifwrite", SIfw, 32'd1);
    expect_v("addi_ctrl", SCtrl, 32'h44);
    expect_v("addi_imm", SImm, 32'd5);
    tick();

    // beq $1,$2,-1 taken; fetch responds with a flush.
    drive(32'h00A03020, 32'h44, 1'b1, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0);
    expect_v("beq_branch", SBr, 32'd1);
    expect_v("beq_jumpaddr", SJa, 32'h3C);
    expect_v("beq_ctrl", SCtrl, 32'h01);
    expect_v("beq_imm", SImm, 32'hFFFF_FFFF);
    tick();
    drive(32'h08000010, 32'h8000_0004, 1'b0, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0);
    expect_v("flush_ctrl", SCtrl, 32'h0);
    expect_v("flush_nextpc", SPc, 32'h0);
    expect_v("flush_branch", SBr, 32'd0);
    tick();
    // j 0x10.
    drive(32'h10230004, 32'h200, 1'b0, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0);
    expect_v("j_jump", SJmp, 32'd1);
    expect_v("j_jumpaddr", SJa, 32'h8000_0040);
    expect_v("j_branch", SBr, 32'd0);
    expect_v("j_ctrl", SCtrl, 32'h0);
    tick();
    // beq $1,$3 unequal: not taken, target still computed.
    drive(32'h01014820, 32'h300, 1'b0, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0);
    expect_v("bne_branch", SBr, 32'd0);
    expect_v("bne_jump", SJmp, 32'd0);
    expect_v("bne_jumpaddr", SJa, 32'h210);
    expect_v("bne_rd2", SRd2, 32'h22);
    tick();

    // Reset during a stall with a pending writeback.
    reset = 1'b1;
    drive(32'h00296820, 32'h400, 1'b0, 1'b1, 5'd9, 32'hDEAD, 1'b1, 5'd8);
    expect_v("rststall_ifwrite", SIfw, 32'd0);
    tick();
    reset = 1'b0;
    drive(32'h00296820, 32'h400, 1'b0, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0);
    expect_v("rst2_ctrl", SCtrl, 32'h0);
    expect_v("rst2_nextpc", SPc, 32'h0);
    expect_v("rst2_ifwrite", SIfw, 32'd1);
    expect_v("rst2_jumpaddr", SJa, 32'h0);
    tick();
    drive(32'h0, 32'h0, 1'b0, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0);
    expect_v("rst2_r1_cleared", SRd1, 32'h0);
    expect_v("rst2_r9_unwritten", SRd2, 32'h0);
    expect_v("rst2_nextpc_loaded", SPc, 32'h400);
    tick();

    @(negedge clk);
    #1;
    if (sb_q.size() != 0) begin
      failures++;
      $display("FAIL scoreboard_drain: got %0d entries expected 0", sb_q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/id_stage.md
ID_STAGE -- requirements
Module: id_stage

Interface
REQ-001 SHALL have port clk  in  1  single clock; all state updates on rising edge.
REQ-002 SHALL have port reset  in  1  synchronous, active-high reset.
REQ-003 SHALL have port Instruction_if  in  32  instruction fetched this cycle.
REQ-004 SHALL have port NextPC_if  in  32  PC+4 of fetched instruction.
REQ-005 SHALL have port IF_flush  in  1  squash fetched instruction (Branch|Jump of fetch stage).
REQ-006 SHALL have port RegWrite_wb  in  1  writeback enable.
REQ-007 SHALL have port WriteReg_wb  in  5  writeback register number.
REQ-008 SHALL have port WriteData_wb  in  32  writeback data.
REQ-009 SHALL have port MemRead_ex  in  1  instruction in EX is a load.
REQ-010 SHALL have port RegisterRt_ex  in  5  destination of load in EX.
REQ-011 SHALL have port IFWrite  out  1  1 = PC/IF-ID may advance, 0 = stall.
REQ-012 SHALL have port Branch  out  1  taken beq resolved in ID.
REQ-013 SHALL have port Jump  out  1  j resolved in ID.
REQ-014 SHALL have port JumpAddr  out  32  redirect target for fetch.
REQ-015 SHALL have ports ReadData1_id, ReadData2_id  out  32 each  rs/rt operands.
REQ-016 SHALL have port Imm_id  out  32  sign-extended instr[15:0].
REQ-017 SHALL have ports Rs_id, Rt_id, Rd_id  out  5 each  instr[25:21], [20:16], [15:11].
REQ-018 SHALL have port NextPC_id  out  32  latched PC+4.
REQ-019 SHALL have port Ctrl_id  out  8  {RegDst, ALUSrc, MemRead, MemWrite, MemtoReg, RegWrite, ALUOp[1:0]}.

Function
REQ-020 IF/ID register (instr, PC+4) SHALL update each edge: IFWrite=0 -> hold; else IF_flush=1 -> load 0 (nop); else load Instruction_if, NextPC_if.
REQ-021 Decode SHALL support opcodes 0x00 R-type, 0x23 lw, 0x2B sw, 0x04 beq, 0x08 addi, 0x02 j; any other opcode, and instr==0, SHALL yield Ctrl_id=0.
REQ-022 Ctrl_id SHALL be: R 8'b1000_0110; lw 8'b0110_1100; sw 8'b0101_0000; beq 8'b0000_0001; addi 8'b0100_0100; j 8'b0.
REQ-023 Register file SHALL be 32x32; register 0 reads 0 always and ignores writes.
REQ-024 Write SHALL occur at edge when RegWrite_wb=1 and WriteReg_wb!=0.
REQ-025 Reads SHALL be combinational with write-through bypass: read index == WriteReg_wb, RegWrite_wb=1, index!=0 -> WriteData_wb returned same cycle.
REQ-026 stall SHALL = MemRead_ex & RegisterRt_ex!=0 & (RegisterRt_ex==Rs_id | (RegisterRt_ex==Rt_id & opcode in {R, sw, beq})).
REQ-027 IFWrite SHALL = ~stall, combinational.
REQ-028 On stall Ctrl_id, Branch, Jump SHALL be 0 (bubble to EX); IF/ID held per REQ-020.
REQ-029 Branch SHALL = beq & ReadData1_id==ReadData2_id & ~stall; no EX/MEM forwarding into compare.
REQ-030 Jump SHALL = (opcode==j) & ~stall.
REQ-031 JumpAddr SHALL = Jump ? {NextPC_id[31:28], instr[25:0], 2'b00} : NextPC_id + (Imm_id<<2), 32-bit wrap, carry discarded.
REQ-032 Branch and Jump SHALL be mutually exclusive; taken redirect causes next-edge IF/ID load of nop via IF_flush.
REQ-033 Stall and IF_flush simultaneously: stall wins (hold); impossible by REQ-028 but SHALL be defined so.

Reset
REQ-034 reset=1 at edge SHALL clear IF/ID register and all 32 registers to 0, overriding writeback and stall.
REQ-035 After reset, outputs SHALL be: IFWrite=1 (if MemRead_ex=0), Branch=Jump=0, Ctrl_id=0, NextPC_id=0, JumpAddr=0.
REQ-036 Reset mid-stall SHALL discard held instruction; no register write in reset cycle.

Verification
REQ-037 Write $5=0x1234 via WB, next cycle add $6,$5,$0 in ID -> ReadData1_id=0x1234, Ctrl_id=8'h86.
REQ-038 Same-cycle WB $7=0xABCD while ID reads $7 -> ReadData1_id=0xABCD; WB to $0 -> $0 reads 0.
REQ-039 lw $8 in EX (MemRead_ex=1, RegisterRt_ex=8), ID add $9,$8,$1 -> IFWrite=0, Ctrl_id=0, IF/ID holds one cycle; rt match with addi -> no stall.
REQ-040 beq $1,$2 equal, NextPC_id=0x40, imm=0xFFFF -> Branch=1, JumpAddr=0x3C, next cycle instr=0.
REQ-041 j 0x0000010 with NextPC_id=0x8000_0004 -> Jump=1, JumpAddr=0x8000_0040; unequal beq -> Branch=0.
REQ-042 reset asserted during stall with pending WB -> all regs 0, IF/ID 0, no write.
